ls_issue_queue: RTL
===================

LS_ISSUE_QUEUE -- requirements
Module: ls_issue_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries (power of two, at least 2).
REQ-002 Parameter W_TAG, 5, width of rename tags.
REQ-003 Clk  in  1  clock; all state changes on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Dispatch_Valid  in  1  new load/store offered.
REQ-006 Dispatch_Opcode  in  1  1 = load, 0 = store.
REQ-007 Dispatch_Rs_Data  in  32  base register value.
REQ-008 Dispatch_Rs_Tag  in  W_TAG  base producer tag.
REQ-009 Dispatch_Rs_Ready  in  1  base value valid.
REQ-010 Dispatch_Rt_Data  in  32  store data value.
REQ-011 Dispatch_Rt_Tag  in  W_TAG  store-data producer tag.
REQ-012 Dispatch_Rt_Ready  in  1  store data valid.
REQ-013 Dispatch_Imm  in  16  signed address offset.
REQ-014 Dispatch_Rd_Tag  in  W_TAG  destination tag of the operation.
REQ-015 Dispatch_Full  out  1  queue cannot accept dispatch.
REQ-016 Cdb_Valid / Cdb_Tag / Cdb_Data  in  1 / W_TAG / 32  common data bus broadcast.
REQ-017 DCache_Data_Out  out  32  store data to cache.
REQ-018 DCache_Address  out  32  effective byte address.
REQ-019 DCache_Tag_Out  out  W_TAG  head Rd tag.
REQ-020 DCache_Opcode  out  1  head opcode.
REQ-021 DCache_Ready_Out  out  1  head entry valid and operands ready.
REQ-022 DCache_Issue_In  in  1  cache accepts head this cycle.

Function
REQ-023 The queue SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap at DEPTH, plus a count of 0..DEPTH.
REQ-024 Dispatch_Full SHALL equal (count == DEPTH), taken from the registered count before any pop in the same cycle.
REQ-025 A dispatch SHALL be accepted when Dispatch_Valid & ~Dispatch_Full; the entry is written at tail, and tail advances at the next edge.
REQ-026 Dispatch while Full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-027 Each valid entry with a not-ready operand whose tag equals Cdb_Tag while Cdb_Valid=1 SHALL capture Cdb_Data and set that operand ready at the next edge.
REQ-028 A dispatching operand with Ready=0 and a same-cycle CDB tag match SHALL be written ready with Cdb_Data (bypass).
REQ-029 A load SHALL need only Rs ready; a store SHALL need Rs and Rt ready.
REQ-030 Issue SHALL be strictly in order: only the head entry may drive the outputs, and a ready younger entry SHALL never issue ahead of a not-ready head.
REQ-031 DCache_Address SHALL equal Rs_Data + sign-extended Imm, computed modulo 2^32, combinationally from the head entry.
REQ-032 DCache_Data_Out SHALL equal Rt_Data for stores and 0 for loads.
REQ-033 DCache_Tag_Out and DCache_Opcode SHALL come from the head entry.
REQ-034 All DCache_* outputs SHALL be 0 when the head entry is invalid.
REQ-035 A pop SHALL occur when DCache_Ready_Out & DCache_Issue_In; the head is invalidated and advances at the next edge.
REQ-036 DCache_Issue_In SHALL be ignored while DCache_Ready_Out = 0.
REQ-037 Simultaneous dispatch and pop SHALL leave count unchanged; dispatch alone adds 1; pop alone subtracts 1.
REQ-038 An entry dispatched into an empty queue SHALL become visible at the outputs no earlier than the cycle after dispatch (zero-cycle pass-through forbidden).
REQ-039 A CDB match on the entry being popped in the same cycle SHALL have no visible effect.

Reset
REQ-040 Rst=1 SHALL immediately clear all entry valid bits, head, tail and count, regardless of the clock.
REQ-041 During and after reset, Dispatch_Full, DCache_Ready_Out, DCache_Data_Out, DCache_Address, DCache_Tag_Out and DCache_Opcode SHALL be 0 until a new dispatch.

Structure
REQ-042 Package ls_pkg SHALL hold W_TAG, OPC_LOAD=1, OPC_STORE=0 and the queue-entry record type (valid, opcode, rs data/tag/ready, rt data/tag/ready, imm, rd tag).
REQ-043 Per-entry CDB snoop and operand capture SHALL live in sub-module ls_queue_entry, instantiated DEPTH times.

Verification
REQ-044 Store: Rs=0x10 ready, Imm=0x0004, Rt=0xAB ready, Rd=3 -> next cycle Ready_Out=1, Address=0x14, Data=0xAB, Opcode=0; Issue_In=1 -> Ready_Out=0 the following cycle.
REQ-045 Load with Rs waiting on tag 7, Imm=0x8 -> Ready_Out stays 0; Cdb_Valid with tag 7 and data 0x20 -> next cycle Ready_Out=1, Address=0x28, Data=0.
REQ-046 Four ready dispatches with no Issue_In -> Full=1 and a fifth dispatch is dropped; one pop -> Full=0, and the remaining entries issue in dispatch order, with pointers wrapping correctly over 8 total operations.
REQ-047 Head store waiting on Rt and entry 2 a ready load -> Ready_Out=0 until the Rt CDB broadcast; the store then issues before the load.
REQ-048 Rs=0x8 with Imm=0xFFFC -> Address=0x4; Rs=0xFFFFFFFC with Imm=0x0008 -> Address=0x4 (wrap).
REQ-049 Rst pulse mid-cycle with 3 entries queued -> outputs 0 and count=0 without a clock edge; the next dispatch issues normally.

Source files
------------

// File: rtl/ls_pkg.sv
// Purpose : shared types and helpers for the load/store issue queue.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: tag width, opcode encodings, queue-entry record, CDB snoop helper.
package ls_pkg;

   localparam int   W_TAG     = 5;
   localparam logic OPC_LOAD  = 1'b1;
   localparam logic OPC_STORE = 1'b0;

   // One queue slot: operation plus both source operands with their
   // producer tags and ready flags.
   typedef struct packed {
      logic             valid;
      logic             opcode;
      logic [31:0]      rs_data;
      logic [W_TAG-1:0] rs_tag;
      logic             rs_ready;
      logic [31:0]      rt_data;
      logic [W_TAG-1:0] rt_tag;
      logic             rt_ready;
      logic [15:0]      imm;
      logic [W_TAG-1:0] rd_tag;
   } ls_entry_t;

   // Apply one CDB broadcast to an entry: every not-ready operand whose tag
   // matches picks up the broadcast value. Used both for resident entries and
   // for an entry being written, so dispatch cannot miss a same-cycle result.
   function automatic ls_entry_t cdb_snoop(input ls_entry_t  e,
                                           input logic       cdb_valid,
                                           input logic [W_TAG-1:0] cdb_tag,
                                           input logic [31:0] cdb_data);
      ls_entry_t r;
      r = e;
      if (cdb_valid && !e.rs_ready && (e.rs_tag == cdb_tag)) begin
         r.rs_data  = cdb_data;
         r.rs_ready = 1'b1;
      end
      if (cdb_valid && !e.rt_ready && (e.rt_tag == cdb_tag)) begin
         r.rt_data  = cdb_data;
         r.rt_ready = 1'b1;
      end
      return r;
   endfunction

   // Loads only need the base; stores also need their data operand.
   function automatic logic entry_issuable(input ls_entry_t e);
      return e.valid && e.rs_ready && ((e.opcode == OPC_LOAD) || e.rt_ready);
   endfunction

endpackage

// File: rtl/ls_queue_entry.sv
// Purpose : one issue-queue slot; holds an operation and snoops the CDB for its operands.
// Latency : write and CDB capture visible one cycle later.
// Backpressure: none; the parent decides when to write or pop.
// Ports   : Clk/Rst; Write_En_i + Write_Entry_i load the slot (CDB bypass applied);
//           Pop_i invalidates it; Cdb_* broadcast; *_o expose the issue-relevant fields.
module ls_queue_entry
   import ls_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Write_En_i,
   input  ls_entry_t        Write_Entry_i,
   input  logic             Pop_i,
   input  logic             Cdb_Valid_i,
   input  logic [W_TAG-1:0] Cdb_Tag_i,
   input  logic [31:0]      Cdb_Data_i,
   output logic             Valid_o,
   output logic             Issuable_o,
   output logic             Opcode_o,
   output logic [31:0]      Rs_Data_o,
   output logic [31:0]      Rt_Data_o,
   output logic [15:0]      Imm_o,
   output logic [W_TAG-1:0] Rd_Tag_o
);

   ls_entry_t entry_q, entry_d;

   // Write and pop never target the same slot in one cycle: a write needs a
   // non-full queue, so tail == head only when the queue is empty.
   // A popped slot ignores the CDB; its contents are dead.
   always_comb begin
      entry_d = entry_q;
      if (Write_En_i) begin
         entry_d = cdb_snoop(Write_Entry_i, Cdb_Valid_i, Cdb_Tag_i, Cdb_Data_i);
      end else if (Pop_i) begin
         entry_d.valid = 1'b0;
      end else if (entry_q.valid) begin
         entry_d = cdb_snoop(entry_q, Cdb_Valid_i, Cdb_Tag_i, Cdb_Data_i);
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign Valid_o    = entry_q.valid;
   assign Issuable_o = entry_issuable(entry_q);
   assign Opcode_o   = entry_q.opcode;
   assign Rs_Data_o  = entry_q.rs_data;
   assign Rt_Data_o  = entry_q.rt_data;
   assign Imm_o      = entry_q.imm;
   assign Rd_Tag_o   = entry_q.rd_tag;

endmodule

// File: rtl/ls_issue_queue.sv
// Purpose : in-order load/store issue queue with CDB operand wakeup, feeding the data cache.
// Latency : a dispatched entry reaches the DCache outputs one cycle after dispatch at the earliest.
// Backpressure: Dispatch_Full stalls dispatch; the head waits until DCache_Issue_In accepts it.
// Ports   : Clk/Rst; Dispatch_* new operation in, Dispatch_Full out; Cdb_* result broadcast;
//           DCache_* head operation out (all zero when empty), DCache_Issue_In pops the head.
module ls_issue_queue
   import ls_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W_TAG = ls_pkg::W_TAG
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Dispatch_Valid,
   input  logic             Dispatch_Opcode,
   input  logic [31:0]      Dispatch_Rs_Data,
   input  logic [W_TAG-1:0] Dispatch_Rs_Tag,
   input  logic             Dispatch_Rs_Ready,
   input  logic [31:0]      Dispatch_Rt_Data,
   input  logic [W_TAG-1:0] Dispatch_Rt_Tag,
   input  logic             Dispatch_Rt_Ready,
   input  logic [15:0]      Dispatch_Imm,
   input  logic [W_TAG-1:0] Dispatch_Rd_Tag,
   output logic             Dispatch_Full,
   input  logic             Cdb_Valid,
   input  logic [W_TAG-1:0] Cdb_Tag,
   input  logic [31:0]      Cdb_Data,
   output logic [31:0]      DCache_Data_Out,
   output logic [31:0]      DCache_Address,
   output logic [W_TAG-1:0] DCache_Tag_Out,
   output logic             DCache_Opcode,
   output logic             DCache_Ready_Out,
   input  logic             DCache_Issue_In
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             push;
   logic             pop;
   ls_entry_t        write_entry;

   logic             ent_vld     [DEPTH];
   logic             ent_issuable[DEPTH];
   logic             ent_opc     [DEPTH];
   logic [31:0]      ent_rs_data [DEPTH];
   logic [31:0]      ent_rt_data [DEPTH];
   logic [15:0]      ent_imm     [DEPTH];
   logic [W_TAG-1:0] ent_rd_tag  [DEPTH];

   logic             head_vld;
   logic [31:0]      head_offset;

   // Full comes from the registered count, so a same-cycle pop never opens
   // room for a dispatch.
   assign Dispatch_Full = (count_q == CNT_W'(DEPTH));
   assign push          = Dispatch_Valid && !Dispatch_Full;
   assign pop           = DCache_Ready_Out && DCache_Issue_In;

   always_comb begin
      write_entry          = '0;
      write_entry.valid    = 1'b1;
      write_entry.opcode   = Dispatch_Opcode;
      write_entry.rs_data  = Dispatch_Rs_Data;
      write_entry.rs_tag   = Dispatch_Rs_Tag;
      write_entry.rs_ready = Dispatch_Rs_Ready;
      write_entry.rt_data  = Dispatch_Rt_Data;
      write_entry.rt_tag   = Dispatch_Rt_Tag;
      write_entry.rt_ready = Dispatch_Rt_Ready;
      write_entry.imm      = Dispatch_Imm;
      write_entry.rd_tag   = Dispatch_Rd_Tag;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      ls_queue_entry u_entry (
         .Clk           (Clk),
         .Rst           (Rst),
         .Write_En_i    (push && (tail_q == PTR_W'(i))),
         .Write_Entry_i (write_entry),
         .Pop_i         (pop && (head_q == PTR_W'(i))),
         .Cdb_Valid_i   (Cdb_Valid),
         .Cdb_Tag_i     (Cdb_Tag),
         .Cdb_Data_i    (Cdb_Data),
         .Valid_o       (ent_vld[i]),
         .Issuable_o    (ent_issuable[i]),
         .Opcode_o      (ent_opc[i]),
         .Rs_Data_o     (ent_rs_data[i]),
         .Rt_Data_o     (ent_rt_data[i]),
         .Imm_o         (ent_imm[i]),
         .Rd_Tag_o      (ent_rd_tag[i])
      );
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Only the head slot drives the cache port; everything is forced to zero
   // while the head slot is empty.
   assign head_vld    = ent_vld[head_q];
   assign head_offset = {{16{ent_imm[head_q][15]}}, ent_imm[head_q]};

   always_comb begin
      DCache_Ready_Out = 1'b0;
      DCache_Opcode    = 1'b0;
      DCache_Tag_Out   = '0;
      DCache_Address   = '0;
      DCache_Data_Out  = '0;
      if (head_vld) begin
         DCache_Ready_Out = ent_issuable[head_q];
         DCache_Opcode    = ent_opc[head_q];
         DCache_Tag_Out   = ent_rd_tag[head_q];
         DCache_Address   = ent_rs_data[head_q] + head_offset;
         if (ent_opc[head_q] == OPC_STORE) begin
            DCache_Data_Out = ent_rt_data[head_q];
         end
      end
   end

endmodule
